dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: DMEM_ARBITER

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to port B while port A waits.
REQ-004 SHALL have a single clock CLK and an asynchronous active-low reset RESET_N: CLK input 1, system clock, rising edge; RESET_N input 1, asynchronous active-low reset.
REQ-005 SHALL have port A (core): REQ_A input 1 access request; WE_A input 1 write(1)/read(0); ADDR_A input ADDR_W address; WDATA_A input DATA_W write data; GNT_A output 1 grant this cycle; RVALID_A output 1 read data valid; RDATA_A output DATA_W read data.
REQ-006 SHALL have port B (loader/debug): REQ_B, WE_B, LOCK_B input 1 (hold ownership request), ADDR_B, WDATA_B; outputs GNT_B, RVALID_B, RDATA_B, with the same widths and meanings as port A.
REQ-007 SHALL have memory side: DIR_DMEM output ADDR_W address; DATA_WRITE_DMEM output DATA_W write data; READ output 1 read strobe; WRITE output 1 write strobe; DATA_READ_DMEM input DATA_W read data, valid one cycle after READ.
REQ-008 SHALL have STALL_CORE output 1, PC hold request to the core.

Function
REQ-009 SHALL assert at most one of GNT_A/GNT_B in any cycle; grant is combinational from current requests and registered state.
REQ-010 SHALL drive DIR_DMEM, DATA_WRITE_DMEM, READ=!WE, WRITE=WE from the granted port; with no grant READ=WRITE=0, DIR_DMEM=0, DATA_WRITE_DMEM=0.
REQ-011 SHALL implement FSM states IDLE and OWN_B.
REQ-012 IDLE: single requester wins; both requesting -> the port not granted most recently wins (1-bit round-robin pointer LAST, updated on every grant).
REQ-013 IDLE -> OWN_B when GNT_B && LOCK_B; burst counter loaded to 1.
REQ-014 OWN_B: B granted whenever REQ_B && LOCK_B && (counter < MAX_BURST || !REQ_A); counter increments per B grant, saturating at MAX_BURST.
REQ-015 OWN_B -> IDLE, counter cleared, when REQ_B=0 or LOCK_B=0 (arbitrate same cycle per REQ-012), or when counter == MAX_BURST && REQ_A (A granted that cycle, LAST=A).
REQ-016 SHALL drive STALL_CORE = REQ_A && !GNT_A.
REQ-017 SHALL register a read-pending flag per port: RVALID_x high exactly one cycle after a cycle with GNT_x && !WE_x; RDATA_x = DATA_READ_DMEM while RVALID_x, else 0.
REQ-018 Write grants SHALL produce no RVALID; back-to-back reads SHALL yield RVALID every cycle.
REQ-019 Request withdrawn before grant SHALL cause no memory access and no RVALID.
REQ-020 ADDR/WDATA/WE of non-granted port SHALL have no effect on memory outputs.

Reset
REQ-021 RESET_N low SHALL asynchronously force: FSM=IDLE, counter=0, LAST=B (A wins first tie), pending-read flags=0.
REQ-022 During reset all outputs SHALL be 0 except as derived combinationally from REQ inputs per REQ-009..016; RVALID_A/B SHALL be 0.
REQ-023 Reset asserted with a read pending SHALL drop the pending RVALID; no RVALID after release for pre-reset grants.

Verification
REQ-024 Reset: RESET_N=0 mid-run -> FSM IDLE, RVALID_A=RVALID_B=0; first tie after release -> GNT_A=1.
REQ-025 Tie: REQ_A read addr 5, REQ_B read addr 9, no lock, 4 cycles -> grants A,B,A,B; DIR_DMEM 5,9,5,9; RVALID alternates one cycle later; STALL_CORE high on cycles 2,4.
REQ-026 Burst: MAX_BURST=8, LOCK_B=1, REQ_B and REQ_A held -> GNT_B cycles 1-8, STALL_CORE=1 cycles 1-8, cycle 9 GNT_A=1, FSM IDLE.
REQ-027 Write: sole REQ_A, WE_A=1, ADDR_A=0x3FF, WDATA_A=0xDEADBEEF -> WRITE=1, READ=0, DIR_DMEM=0x3FF, DATA_WRITE_DMEM=0xDEADBEEF, no RVALID_A next cycle.
REQ-028 Unlock: OWN_B with LOCK_B dropped at count 3, REQ_A high -> GNT_A same cycle, counter 0.
REQ-029 Reset mid-read: GNT_B read then RESET_N=0 before next edge -> RVALID_B never asserts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (A) vs loader/debug (B) with 1-bit round-robin
// and a bounded locked-burst mode for B. Grants are combinational; read-valids are registered.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  // Port A (core)
  input  logic              REQ_A,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] WDATA_A,
  output logic              GNT_A,
  output logic              RVALID_A,
  output logic [DATA_W-1:0] RDATA_A,
  // Port B (loader/debug)
  input  logic              REQ_B,
  input  logic              WE_B,
  input  logic              LOCK_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_B,
  output logic              RVALID_B,
  output logic [DATA_W-1:0] RDATA_B,
  // Memory side
  output logic [ADDR_W-1:0] DIR_DMEM,
  output logic [DATA_W-1:0] DATA_WRITE_DMEM,
  output logic              READ,
  output logic              WRITE,
  input  logic [DATA_W-1:0] DATA_READ_DMEM,
  output logic              STALL_CORE
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StOwnB} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_b_q, last_b_d;    // 1: B was granted most recently
  logic            rpend_a_q, rpend_a_d;
  logic            rpend_b_q, rpend_b_d;
  logic            gnt_a, gnt_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_a = REQ_A && (!REQ_B || last_b_q);
        gnt_b = REQ_B && !gnt_a;
        if (gnt_b && LOCK_B) begin
          state_d = StOwnB;
          cnt_d   = CntW'(1);
        end
      end
      StOwnB: begin
        if (REQ_B && LOCK_B) begin
          if ((cnt_q < MaxCnt) || !REQ_A) begin
            gnt_b = 1'b1;
            if (cnt_q < MaxCnt) cnt_d = cnt_q + 1'b1;
          end else begin
            // Burst budget spent while the core waits: hand one cycle to A.
            gnt_a   = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          // Lock released: fall back to round-robin in the same cycle.
          state_d = StIdle;
          cnt_d   = '0;
          gnt_a   = REQ_A && (!REQ_B || last_b_q);
          gnt_b   = REQ_B && !gnt_a;
        end
      end
    endcase
    if (gnt_a) begin
      last_b_d = 1'b0;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
    end
    rpend_a_d = gnt_a && !WE_A;
    rpend_b_d = gnt_b && !WE_B;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      rpend_a_q <= 1'b0;
      rpend_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      rpend_a_q <= rpend_a_d;
      rpend_b_q <= rpend_b_d;
    end
  end

  always_comb begin
    DIR_DMEM        = '0;
    DATA_WRITE_DMEM = '0;
    READ            = 1'b0;
    WRITE           = 1'b0;
    if (gnt_a) begin
      DIR_DMEM        = ADDR_A;
      DATA_WRITE_DMEM = WDATA_A;
      READ            = !WE_A;
      WRITE           = WE_A;
    end else if (gnt_b) begin
      DIR_DMEM        = ADDR_B;
      DATA_WRITE_DMEM = WDATA_B;
      READ            = !WE_B;
      WRITE           = WE_B;
    end
  end

  assign GNT_A      = gnt_a;
  assign GNT_B      = gnt_b;
  assign STALL_CORE = REQ_A && !gnt_a;
  assign RVALID_A   = rpend_a_q;
  assign RVALID_B   = rpend_b_q;
  assign RDATA_A    = rpend_a_q ? DATA_READ_DMEM : '0;
  assign RDATA_B    = rpend_b_q ? DATA_READ_DMEM : '0;

endmodule
